p405s_gpr_addr_pre_enc: RTL
===========================

Name: p405s_gpr_addr_pre_enc

Overview:
- Re-encodes predecoded GPR address words back into 5-bit binary GPR addresses.
- Input word layout: 2-bit msb pair, 4-bit hi one-hot group, 4-bit lo one-hot group.
- Sits on the writeback/trace path, where predecoded addresses must be compared, logged or forwarded in binary form.
- Registered pipeline stage with valid/ready handshake, 2-entry skid buffer, per-word legality check, sticky error flag and saturating error counter.

Parameters:
- ERR_CNT_W, 4, width of the saturating illegal-word counter.
- CHECK_EN, 1, when 0 the legality check is bypassed: ERR bits read 0 and the counter holds 0.

Ports:
- CB  input  1  core clock; all state updates on rising edge.
- resetCore  input  1  synchronous, active-high reset.
- PREDCD_IN  input  [0:9]  predecoded address. [0]=~a0, [1]=a0. [2:5] one-hot of {a1,a2}, index 2*a1+a2. [6:9] one-hot of {a3,a4}, index 2*a3+a4. Bit a0 is the MSB, [0:4] big-endian.
- IN_VALID  input  1  PREDCD_IN valid.
- IN_READY  output  1  block can accept a word.
- ADDR_OUT  output  [0:4]  binary GPR address.
- ADDR_ERR  output  1  word accompanying ADDR_OUT was illegal.
- OUT_VALID  output  1  ADDR_OUT/ADDR_ERR valid.
- OUT_READY  input  1  downstream accepts.
- ERR_STICKY  output  1  set on any accepted illegal word; cleared only by reset or ERR_CLR.
- ERR_CLR  input  1  clears ERR_STICKY and ERR_CNT.
- ERR_CNT  output  [0:ERR_CNT_W-1]  saturating count of accepted illegal words.

Behaviour:
- Transfer rules:
  - Input transfer occurs when IN_VALID & IN_READY.
  - Output transfer occurs when OUT_VALID & OUT_READY.
- Encoding:
  - a0 = PREDCD_IN[1].
  - {a1,a2} = index of the set bit in [2:5].
  - {a3,a4} = index of the set bit in [6:9].
- Legality (CHECK_EN=1). A word is legal only if all of the following hold:
  - [0] != [1];
  - exactly one bit of [2:5] is set;
  - exactly one bit of [6:9] is set.
- Illegal word handling:
  - ADDR_OUT is forced to 5'b00000 and ADDR_ERR=1.
  - The word is still transferred; it is never dropped.
- Latency:
  - 1 cycle from input transfer to OUT_VALID when the buffer is empty.
  - Output comes from registers only; there is no combinational path from PREDCD_IN to ADDR_OUT.
- Buffer: 2-entry skid buffer holding {addr[0:4], err}. FSM states:
  - EMPTY (IN_READY=1, OUT_VALID=0)
    - input transfer -> ONE.
  - ONE (IN_READY=1, OUT_VALID=1)
    - input only -> TWO;
    - output only -> EMPTY;
    - both at once -> stays ONE, new word replaces the head.
  - TWO (IN_READY=0, OUT_VALID=1)
    - output transfer -> ONE; the second entry advances to the head.
- Ordering: strictly in-order. IN_READY is registered: it depends only on state, not on OUT_READY in the same cycle.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, ADDR_OUT and ADDR_ERR must stay stable.
- Error counter:
  - ERR_CNT increments by 1 per accepted illegal word.
  - It saturates at 2^ERR_CNT_W-1 and does not wrap.
  - ERR_STICKY goes high the cycle after the first illegal input transfer.
- Error clear:
  - ERR_CLR has priority over a simultaneous illegal accept; result is 0/0 that cycle.
  - The illegal word is still passed downstream with ADDR_ERR=1.
- Reset (resetCore=1, synchronous):
  - Outputs after reset: state EMPTY, IN_READY=1, OUT_VALID=0, ADDR_OUT=0, ADDR_ERR=0, ERR_STICKY=0, ERR_CNT=0.
  - Reset mid-operation discards buffered words.
  - Inputs presented during the reset cycle are not accepted.
- OUT_READY asserted while OUT_VALID=0 has no effect.
- IN_VALID asserted while IN_READY=0 has no effect; the word must be held by the source.

Decomposition:
- Shared package p405s_gpr_pkg:
  - constants GPR_ADDR_W=5 and PREDCD_W=10;
  - group field offsets: MSB [0:1], HI [2:5], LO [6:9];
  - typedef for the {addr, err} buffer entry.
- One natural sub-module: p405s_gpr_predcd_chk. It is purely combinational: one-hot encode plus legality check, producing {addr[0:4], err}. The encoder instantiates it once at the input ahead of the skid buffer.

Test Plan:
- Round trip, OUT_READY=1: sweep all 32 addresses through the predecoder function, one per cycle. Each ADDR_OUT must equal the source address one cycle after acceptance, ADDR_ERR=0, and IN_READY must stay 1. Example: 0101000010 -> 10110.
- Backpressure: hold OUT_READY=0, send 00001 then 11111. IN_READY must drop after the 2nd accept while ADDR_OUT holds 00001. Then raise OUT_READY: 00001 and then 11111 must emerge in order.
- Illegal words:
  - 1101000010 (msb pair both set) -> ADDR_OUT=0, ADDR_ERR=1, ERR_STICKY=1, ERR_CNT=1.
  - 0100000010 (hi group empty) -> ERR_CNT=2.
- Saturation and clear:
  - 20 illegal words with ERR_CNT_W=4 -> ERR_CNT=15.
  - ERR_CLR concurrent with a further illegal word -> ERR_CNT=0, ERR_STICKY=0, and that word still exits with ADDR_ERR=1.
- Reset mid-flight: buffer holding 2 words, assert resetCore for 1 cycle. The next cycle must show OUT_VALID=0, IN_READY=1 and counters at 0; the discarded words must never appear.
- CHECK_EN=0 with 1101000010 -> ADDR_ERR=0, ERR_CNT stays 0.

Source files
------------

// File: rtl/p405s_gpr_pkg.sv
// p405s_gpr_pkg: shared constants, field offsets and types for the GPR predecode re-encoder
package p405s_gpr_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int PREDCD_W   = 10;
    localparam int GROUP_W    = 4;
    localparam int MSB_OFS    = 0;
    localparam int HI_OFS     = 2;
    localparam int LO_OFS     = 6;

    typedef struct packed {
        logic [0:GPR_ADDR_W-1] addr;
        logic                  err;
    } gpr_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/p405s_gpr_predcd_chk.sv
// p405s_gpr_predcd_chk: combinational one-hot re-encode and legality check of a predecoded GPR address
module p405s_gpr_predcd_chk
    import p405s_gpr_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic [0:PREDCD_W-1] predcd,
    output gpr_entry_t          ent
);

    logic [0:GROUP_W-1] hi;
    logic [0:GROUP_W-1] lo;
    logic               legal;
    logic               err;

    assign hi    = predcd[HI_OFS +: GROUP_W];
    assign lo    = predcd[LO_OFS +: GROUP_W];
    assign legal = (predcd[MSB_OFS] != predcd[MSB_OFS+1]) && $onehot(hi) && $onehot(lo);
    assign err   = CHECK_EN && !legal;

    assign ent.err  = err;
    assign ent.addr = err ? '0 : {predcd[MSB_OFS+1], hi[2] | hi[3], hi[1] | hi[3], lo[2] | lo[3], lo[1] | lo[3]};

endmodule

// File: rtl/p405s_gpr_addr_pre_enc.sv
// p405s_gpr_addr_pre_enc: registered predecode-to-binary GPR address stage with 2-entry skid buffer and error tracking
module p405s_gpr_addr_pre_enc
    import p405s_gpr_pkg::*;
#(
    parameter int ERR_CNT_W = 4,
    parameter bit CHECK_EN  = 1'b1
) (
    input  logic                  CB,
    input  logic                  resetCore,
    input  logic [0:PREDCD_W-1]   PREDCD_IN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [0:GPR_ADDR_W-1] ADDR_OUT,
    output logic                  ADDR_ERR,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  ERR_STICKY,
    input  logic                  ERR_CLR,
    output logic [0:ERR_CNT_W-1]  ERR_CNT
);

    buf_state_t           state_q, state_d;
    gpr_entry_t           head_q, head_d;
    gpr_entry_t           tail_q, tail_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [0:ERR_CNT_W-1] err_cnt_q, err_cnt_d;
    gpr_entry_t           in_ent;
    logic                 in_xfer;
    logic                 out_xfer;

    p405s_gpr_predcd_chk #(.CHECK_EN(CHECK_EN)) u_chk (
        .predcd (PREDCD_IN),
        .ent    (in_ent)
    );

    assign IN_READY   = state_q != TWO;
    assign OUT_VALID  = state_q != EMPTY;
    assign ADDR_OUT   = head_q.addr;
    assign ADDR_ERR   = head_q.err;
    assign ERR_STICKY = err_sticky_q;
    assign ERR_CNT    = err_cnt_q;
    assign in_xfer    = IN_VALID && IN_READY;
    assign out_xfer   = OUT_VALID && OUT_READY;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (in_xfer) begin
                state_d = ONE;
                head_d  = in_ent;
            end
            ONE: if (in_xfer && out_xfer) begin
                head_d = in_ent;
            end else if (in_xfer) begin
                state_d = TWO;
                tail_d  = in_ent;
            end else if (out_xfer) begin
                state_d = EMPTY;
            end
            TWO: if (out_xfer) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
        err_sticky_d = ERR_CLR ? 1'b0 : err_sticky_q || (in_xfer && in_ent.err);
        err_cnt_d    = ERR_CLR ? '0
                     : (in_xfer && in_ent.err && !(&err_cnt_q)) ? err_cnt_q + ERR_CNT_W'(1)
                     : err_cnt_q;
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            state_q      <= EMPTY;
            head_q       <= '0;
            tail_q       <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule
